// File: rtl/ad_framer_pkg.sv
// rtl/ad_framer_pkg.sv - shared FSM state type, framing constants and the CRC-8 byte step
package ad_framer_pkg;

  typedef enum logic [2:0] {IDLE, HDR, SEQ, PAY, CHK} state_t;

  localparam logic [7:0] DEFAULT_PREAMBLE = 8'hA5;
  localparam logic [7:0] CRC8_POLY        = 8'h07;

  // One byte of MSB-first CRC-8, unrolled over the eight bits
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/ad_sample_framer_if.sv
// rtl/ad_sample_framer_if.sv - framed byte stream from the framer to the sender link stage
interface ad_sample_framer_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/ad_framer_fifo.sv
// rtl/ad_framer_fifo.sv - synchronous first-word-fall-through sample buffer
module ad_framer_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      din,
  output logic [DATA_W-1:0]      dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  // A push into a full buffer is accepted when a pop frees the head slot in the same cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ad_sample_framer.sv
// rtl/ad_sample_framer.sv - samples the ADC bus and packs samples into preamble/seq/payload/check frames
// Check byte is XOR by default; defining AD_FRAMER_CRC8_EN selects CRC-8 instead.
module ad_sample_framer
  import ad_framer_pkg::*;
#(
  parameter int         SAMPLE_PERIOD = 720,
  parameter int         PAYLOAD_LEN   = 4,
  parameter int         FIFO_DEPTH    = 8,
  parameter logic [7:0] PREAMBLE      = DEFAULT_PREAMBLE
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sync_in,
  input  logic [7:0]         ad,
  output logic               overflow,
  ad_sample_framer_if.master out
);
  localparam int TW = $clog2(SAMPLE_PERIOD);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(PAYLOAD_LEN + 1);
  localparam logic [TW-1:0] TICK_MAX = TW'(SAMPLE_PERIOD - 1);
  localparam logic [PW-1:0] PAY_MAX  = PW'(PAYLOAD_LEN);
  localparam logic [CW-1:0] PAY_NEED = CW'(PAYLOAD_LEN);

  state_t        state;
  logic [TW-1:0] tick;
  logic [7:0]    seq;
  logic [7:0]    check;
  logic [PW-1:0] pay_cnt;
  logic          capture;
  logic          hs;
  logic          pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  function automatic logic [7:0] check_upd(input logic [7:0] c, input logic [7:0] d);
`ifdef AD_FRAMER_CRC8_EN
    return crc8_byte(c, d);
`else
    return c ^ d;
`endif
  endfunction

  assign capture = sync_in && (tick == TICK_MAX);
  assign hs      = out.out_valid && out.out_ready;
  // out_data is registered, so the head is popped as it is loaded; the load happens on the previous byte's handshake
  assign pop     = hs && !fifo_empty && ((state == SEQ) || (state == PAY && pay_cnt != PAY_MAX));

  ad_framer_fifo #(.DATA_W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (capture),
    .pop   (pop),
    .din   (ad),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (reset || !sync_in)    tick <= '0;
    else if (tick == TICK_MAX) tick <= '0;
    else                       tick <= tick + TW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset)                                overflow <= 1'b0;
    else if (capture && fifo_full && !pop)    overflow <= 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      seq           <= 8'h00;
      check         <= 8'h00;
      pay_cnt       <= '0;
      out.out_data  <= 8'h00;
      out.out_valid <= 1'b0;
      out.out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (fifo_count >= PAY_NEED) begin
          state         <= HDR;
          out.out_data  <= PREAMBLE;
          out.out_valid <= 1'b1;
        end
        HDR: if (hs) begin
          state        <= SEQ;
          out.out_data <= seq;
        end
        SEQ: if (hs) begin
          state        <= PAY;
          check        <= check_upd(8'h00, seq);
          out.out_data <= fifo_dout;
          pay_cnt      <= PW'(1);
        end
        PAY: if (hs) begin
          check <= check_upd(check, out.out_data);
          if (pay_cnt == PAY_MAX) begin
            state        <= CHK;
            out.out_data <= check_upd(check, out.out_data);
            out.out_last <= 1'b1;
          end else begin
            out.out_data <= fifo_dout;
            pay_cnt      <= pay_cnt + PW'(1);
          end
        end
        CHK: if (hs) begin
          state         <= IDLE;
          seq           <= seq + 8'd1;
          out.out_data  <= 8'h00;
          out.out_valid <= 1'b0;
          out.out_last  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ad_sample_framer.sv
// tb/tb_ad_sample_framer.sv - directed self-checking bench for ad_sample_framer (SAMPLE_PERIOD=4)
module tb_ad_sample_framer;
  localparam int P = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       sync_in;
  logic [7:0] ad;
  logic       overflow;

  ad_sample_framer_if bus();

  ad_sample_framer #(.SAMPLE_PERIOD(P), .PAYLOAD_LEN(4), .FIFO_DEPTH(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .sync_in  (sync_in),
    .ad       (ad),
    .overflow (overflow),
    .out      (bus)
  );

  always #5 clock = ~clock;

  int         n_checks = 0;
  int         n_fail   = 0;
  bit         stalled  = 1'b0;
  logic [7:0] fb    [7];
  logic       fl    [7];
  logic [7:0] exp_b [7];

  // Reference check byte: bit-serial CRC-8 (poly 07) or plain XOR
  function automatic logic [7:0] ref_check(input logic [7:0] s, input logic [7:0] p0,
                                           input logic [7:0] p1, input logic [7:0] p2,
                                           input logic [7:0] p3);
    logic [7:0] b [5];
    logic [7:0] c;
    logic       f;
    b = '{s, p0, p1, p2, p3};
    c = 8'h00;
    for (int i = 0; i < 5; i++) begin
`ifdef AD_FRAMER_CRC8_EN
      for (int k = 7; k >= 0; k--) begin
        f = c[7] ^ b[i][k];
        c = {c[6:0], 1'b0};
        if (f) c = c ^ 8'h07;
      end
`else
      f = 1'b0;
      c = c ^ b[i];
`endif
    end
    return c;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Holds each sample for one full period; returns on the negedge after its capture edge
  task automatic feed(input logic [7:0] base, input int n);
    sync_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      ad = base + 8'(i);
      repeat (P) @(negedge clock);
    end
  endtask

  // Entered at a negedge; returns at the negedge after the handshake edge
  task automatic get_byte(output logic [7:0] d, output logic l);
    int n;
    n = 0;
    d = 8'h00;
    l = 1'b0;
    if (stalled) return;
    while (!(bus.out_valid && bus.out_ready) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      stalled = 1'b1;
      n_checks++;
      n_fail++;
      $display("FAIL byte_timeout: no handshake after %0d cycles, required one", n);
    end else begin
      d = bus.out_data;
      l = bus.out_last;
      @(negedge clock);
    end
  endtask

  task automatic read_frame();
    for (int i = 0; i < 7; i++) get_byte(fb[i], fl[i]);
  endtask

  task automatic test_reset();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b required 0", bus.out_valid); end
    n_checks++;
    if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %02h required 00", bus.out_data); end
    n_checks++;
    if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL rst_last: got %b required 0", bus.out_last); end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b required 0", overflow); end
    n_checks++;
    if (dut.tick !== '0) begin n_fail++; $display("FAIL rst_tick: got %0d required 0", dut.tick); end
  endtask

  task automatic test_basic_frame();
    bus.out_ready = 1'b1;
    feed(8'h20, 4);
    sync_in = 1'b0;
    read_frame();
    exp_b = '{8'hA5, 8'h00, 8'h20, 8'h21, 8'h22, 8'h23, ref_check(8'h00, 8'h20, 8'h21, 8'h22, 8'h23)};
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (fb[i] !== exp_b[i] || fl[i] !== (i == 6))
        begin n_fail++; $display("FAIL basic_b%0d: got %02h last %b, required %02h last %b", i, fb[i], fl[i], exp_b[i], i == 6); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.out_ready = 1'b1;
    feed(8'h20, 4);
    sync_in = 1'b0;
    for (int i = 0; i < 3; i++) get_byte(fb[i], fl[i]);
    bus.out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h21 || bus.out_last !== 1'b0)
        begin n_fail++; $display("FAIL bp_hold%0d: got v%b d%02h l%b, required v1 d21 l0", c, bus.out_valid, bus.out_data, bus.out_last); end
    end
    bus.out_ready = 1'b1;
    for (int i = 3; i < 7; i++) get_byte(fb[i], fl[i]);
    exp_b = '{8'hA5, 8'h00, 8'h20, 8'h21, 8'h22, 8'h23, ref_check(8'h00, 8'h20, 8'h21, 8'h22, 8'h23)};
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (fb[i] !== exp_b[i] || fl[i] !== (i == 6))
        begin n_fail++; $display("FAIL bp_b%0d: got %02h last %b, required %02h last %b", i, fb[i], fl[i], exp_b[i], i == 6); end
    end
  endtask

  task automatic test_overflow();
    bit seen;
    do_reset();
    bus.out_ready = 1'b0;
    feed(8'h30, 8);
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_before: got %b required 0", overflow); end
    feed(8'h38, 1);
    sync_in = 1'b0;
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_after: got %b required 1", overflow); end
    bus.out_ready = 1'b1;
    read_frame();
    exp_b = '{8'hA5, 8'h00, 8'h30, 8'h31, 8'h32, 8'h33, ref_check(8'h00, 8'h30, 8'h31, 8'h32, 8'h33)};
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (fb[i] !== exp_b[i] || fl[i] !== (i == 6))
        begin n_fail++; $display("FAIL ovf_f0_b%0d: got %02h last %b, required %02h last %b", i, fb[i], fl[i], exp_b[i], i == 6); end
    end
    read_frame();
    exp_b = '{8'hA5, 8'h01, 8'h34, 8'h35, 8'h36, 8'h37, ref_check(8'h01, 8'h34, 8'h35, 8'h36, 8'h37)};
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (fb[i] !== exp_b[i] || fl[i] !== (i == 6))
        begin n_fail++; $display("FAIL ovf_f1_b%0d: got %02h last %b, required %02h last %b", i, fb[i], fl[i], exp_b[i], i == 6); end
    end
    seen = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (bus.out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL ovf_no_third: got valid seen %b required 0", seen); end
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b required 1", overflow); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    logic       l;
    bus.out_ready = 1'b1;
    feed(8'h50, 4);
    sync_in = 1'b0;
    get_byte(d, l);
    n_checks++;
    if (d !== 8'hA5) begin n_fail++; $display("FAIL rmf_hdr: got %02h required a5", d); end
    n_checks++;
    if (bus.out_data !== 8'h02 || bus.out_valid !== 1'b1)
      begin n_fail++; $display("FAIL rmf_seq: got v%b d%02h required v1 d02", bus.out_valid, bus.out_data); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || overflow !== 1'b0 || bus.out_last !== 1'b0 || bus.out_data !== 8'h00)
      begin n_fail++; $display("FAIL rmf_cleared: got v%b o%b l%b d%02h required v0 o0 l0 d00", bus.out_valid, overflow, bus.out_last, bus.out_data); end
    feed(8'h60, 4);
    sync_in = 1'b0;
    read_frame();
    exp_b = '{8'hA5, 8'h00, 8'h60, 8'h61, 8'h62, 8'h63, ref_check(8'h00, 8'h60, 8'h61, 8'h62, 8'h63)};
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (fb[i] !== exp_b[i] || fl[i] !== (i == 6))
        begin n_fail++; $display("FAIL rmf_b%0d: got %02h last %b, required %02h last %b", i, fb[i], fl[i], exp_b[i], i == 6); end
    end
  endtask

  task automatic test_sync_drop();
    do_reset();
    bus.out_ready = 1'b0;
    feed(8'h40, 6);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) get_byte(fb[i], fl[i]);
    sync_in = 1'b0;
    for (int i = 3; i < 7; i++) get_byte(fb[i], fl[i]);
    exp_b = '{8'hA5, 8'h00, 8'h40, 8'h41, 8'h42, 8'h43, ref_check(8'h00, 8'h40, 8'h41, 8'h42, 8'h43)};
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (fb[i] !== exp_b[i] || fl[i] !== (i == 6))
        begin n_fail++; $display("FAIL sd_b%0d: got %02h last %b, required %02h last %b", i, fb[i], fl[i], exp_b[i], i == 6); end
    end
    repeat (12) @(negedge clock);
    n_checks++;
    if (dut.tick !== '0) begin n_fail++; $display("FAIL sd_tick: got %0d required 0", dut.tick); end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL sd_idle: got valid %b required 0", bus.out_valid); end
    n_checks++;
    if (dut.u_fifo.count !== 4'd2) begin n_fail++; $display("FAIL sd_leftover: got %0d required 2", dut.u_fifo.count); end
  endtask

  task automatic test_seq_wrap();
    do_reset();
    bus.out_ready = 1'b1;
    for (int f = 0; f < 257; f++) begin
      feed(8'(f), 4);
      sync_in = 1'b0;
      read_frame();
      n_checks++;
      if (fb[0] !== 8'hA5 || fb[1] !== 8'(f) || fl[6] !== 1'b1)
        begin n_fail++; $display("FAIL wrap_f%0d: got hdr %02h seq %02h last %b, required a5 %02h 1", f, fb[0], fb[1], fl[6], 8'(f)); end
    end
  endtask

  initial begin
    reset         = 1'b1;
    sync_in       = 1'b0;
    ad            = 8'h00;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clock);
    test_reset();
    reset = 1'b0;
    test_basic_frame();
    test_backpressure();
    test_overflow();
    test_reset_midframe();
    test_sync_drop();
    test_seq_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
